// File: rtl/alu_sequencer_if.sv
// Request, ALU and response signals of the ALU issue sequencer.
// The master side issues requests and provides the ALU; the slave side is the sequencer.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        rsp_zero;
  logic        rsp_div0;
  logic        rsp_illegal;
  logic        busy;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b, rsp_valid, z_hi, z_lo,
           rsp_zero, rsp_div0, rsp_illegal, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b, rsp_valid, z_hi, z_lo,
           rsp_zero, rsp_div0, rsp_illegal, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issue controller for a combinational 32-bit ALU: holds operands stable for a
// per-op settle window, captures the 64-bit result and returns it over valid/ready.
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input logic             clock,
  input logic             clear,
  alu_sequencer_if.slave  seq
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {K_NORMAL, K_DIV0, K_ILLEGAL} kind_t;

  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_MAX = 4'b1010;
  localparam logic [3:0] MUL_M1 = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_M1 = 4'(DIV_CYCLES - 1);

  state_t     state, next_state;
  kind_t      kind, kind_n;
  logic [3:0] cnt, cnt_load;
  logic       accept, capture;

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    seq.req_ready = 1'b0;
    seq.rsp_valid = 1'b0;
    seq.busy      = 1'b1;
    accept        = 1'b0;
    capture       = 1'b0;
    unique case (state)
      IDLE: begin
        seq.req_ready = 1'b1;
        seq.busy      = 1'b0;
        accept        = seq.req_valid;
        if (seq.req_valid) next_state = EXEC;
      end
      EXEC: begin
        capture = (cnt == 4'd0);
        if (cnt == 4'd0) next_state = DONE;
      end
      DONE: begin
        seq.rsp_valid = 1'b1;
        if (seq.rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Special ops are classified at accept so the capture edge needs no operand decode.
  always_comb begin
    kind_n   = K_NORMAL;
    cnt_load = 4'd0;
    if (seq.req_op > OP_MAX) begin
      kind_n = K_ILLEGAL;
    end else if (seq.req_op == OP_DIV) begin
      if (seq.req_b == '0) kind_n   = K_DIV0;
      else                 cnt_load = DIV_M1;
    end else if (seq.req_op == OP_MUL) begin
      cnt_load = MUL_M1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      seq.alu_op      <= '0;
      seq.alu_a       <= '0;
      seq.alu_b       <= '0;
      seq.z_hi        <= '0;
      seq.z_lo        <= '0;
      seq.rsp_zero    <= 1'b0;
      seq.rsp_div0    <= 1'b0;
      seq.rsp_illegal <= 1'b0;
      cnt             <= '0;
      kind            <= K_NORMAL;
    end else begin
      if (accept) begin
        seq.alu_op <= seq.req_op;
        seq.alu_a  <= seq.req_a;
        seq.alu_b  <= seq.req_b;
        cnt        <= cnt_load;
        kind       <= kind_n;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        if (kind == K_NORMAL) begin
          seq.z_hi     <= seq.alu_result[63:32];
          seq.z_lo     <= seq.alu_result[31:0];
          seq.rsp_zero <= seq.alu_zero;
        end else begin
          seq.z_hi     <= '0;
          seq.z_lo     <= '0;
          seq.rsp_zero <= 1'b1;
        end
        seq.rsp_div0    <= (kind == K_DIV0);
        seq.rsp_illegal <= (kind == K_ILLEGAL);
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural stand-in ALU.
module tb_alu_sequencer;
  logic clock;
  logic clear;
  int   pass_cnt;
  int   total_cnt;
  logic [63:0] alu_res;

  alu_sequencer_if sif ();

  alu_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
    .clock (clock),
    .clear (clear),
    .seq   (sif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in ALU: 0000 AND, 0011 ADD, 0100 SUB, 0101 MUL, 0110 DIV {rem,quo}
  always_comb begin
    alu_res = '0;
    case (sif.alu_op)
      4'b0000: alu_res = {32'd0, sif.alu_a & sif.alu_b};
      4'b0011: alu_res = {32'd0, sif.alu_a} + {32'd0, sif.alu_b};
      4'b0100: alu_res = {32'd0, sif.alu_a - sif.alu_b};
      4'b0101: alu_res = {32'd0, sif.alu_a} * {32'd0, sif.alu_b};
      4'b0110: if (sif.alu_b != 0) alu_res = {sif.alu_a % sif.alu_b, sif.alu_a / sif.alu_b};
      default: alu_res = '0;
    endcase
    sif.alu_result = alu_res;
    sif.alu_zero   = (alu_res == 64'd0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    sif.req_op    = op;
    sif.req_a     = a;
    sif.req_b     = b;
    sif.req_valid = 1'b1;
    tick();
    sif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!sif.rsp_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    sif.req_valid = 1'b1;
    sif.req_op = 4'b0011;
    sif.rsp_ready = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    sif.req_valid = 1'b0;
    total_cnt++;
    if ({sif.req_ready, sif.rsp_valid, sif.busy, sif.rsp_zero, sif.rsp_div0, sif.rsp_illegal} !== 6'b100000)
      $display("FAIL reset_flags: got %b need 100000",
        {sif.req_ready, sif.rsp_valid, sif.busy, sif.rsp_zero, sif.rsp_div0, sif.rsp_illegal});
    else pass_cnt++;
    total_cnt++;
    if ({sif.z_hi, sif.z_lo, sif.alu_op, sif.alu_a, sif.alu_b} !== 132'd0)
      $display("FAIL reset_data: got z=%h_%h op=%h a=%h b=%h need all 0",
        sif.z_hi, sif.z_lo, sif.alu_op, sif.alu_a, sif.alu_b);
    else pass_cnt++;
  endtask

  task automatic test_add();
    int n;
    issue(4'b0011, 32'd5, 32'd7);
    total_cnt++;
    if ({sif.req_ready, sif.busy} !== 2'b01)
      $display("FAIL add_busy: got ready/busy=%b need 01", {sif.req_ready, sif.busy});
    else pass_cnt++;
    wait_rsp(n);
    total_cnt++;
    if (n !== 1) $display("FAIL add_latency: got %0d need 1", n);
    else pass_cnt++;
    total_cnt++;
    if ({sif.z_hi, sif.z_lo, sif.rsp_zero} !== {32'd0, 32'd12, 1'b0})
      $display("FAIL add_result: got %h_%h zero=%b need 0_c zero=0", sif.z_hi, sif.z_lo, sif.rsp_zero);
    else pass_cnt++;
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
    total_cnt++;
    if ({sif.req_ready, sif.rsp_valid, sif.z_lo} !== {2'b10, 32'd12})
      $display("FAIL add_handshake: got ready=%b valid=%b z_lo=%0d need 1 0 12",
        sif.req_ready, sif.rsp_valid, sif.z_lo);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    int n;
    issue(4'b0101, 32'h0001_0000, 32'h0001_0000);
    wait_rsp(n);
    total_cnt++;
    if (n !== 4) $display("FAIL mul_latency: got %0d need 4", n);
    else pass_cnt++;
    total_cnt++;
    if ({sif.z_hi, sif.z_lo, sif.rsp_div0, sif.rsp_illegal} !== {32'd1, 32'd0, 2'b00})
      $display("FAIL mul_result: got %h_%h div0=%b ill=%b need 1_0 0 0",
        sif.z_hi, sif.z_lo, sif.rsp_div0, sif.rsp_illegal);
    else pass_cnt++;
    total_cnt++;
    if ({sif.alu_op, sif.alu_a, sif.alu_b} !== {4'b0101, 32'h0001_0000, 32'h0001_0000})
      $display("FAIL mul_alu_hold: got op=%h a=%h b=%h", sif.alu_op, sif.alu_a, sif.alu_b);
    else pass_cnt++;
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
  endtask

  task automatic test_div();
    int n;
    issue(4'b0110, 32'd17, 32'd5);
    wait_rsp(n);
    total_cnt++;
    if (n !== 8) $display("FAIL div_latency: got %0d need 8", n);
    else pass_cnt++;
    total_cnt++;
    if ({sif.z_hi, sif.z_lo, sif.rsp_div0} !== {32'd2, 32'd3, 1'b0})
      $display("FAIL div_result: got rem=%0d quo=%0d div0=%b need 2 3 0", sif.z_hi, sif.z_lo, sif.rsp_div0);
    else pass_cnt++;
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
    issue(4'b0110, 32'd9, 32'd0);
    wait_rsp(n);
    total_cnt++;
    if (n !== 1) $display("FAIL div0_latency: got %0d need 1", n);
    else pass_cnt++;
    total_cnt++;
    if ({sif.z_hi, sif.z_lo, sif.rsp_zero, sif.rsp_div0, sif.rsp_illegal} !== {64'd0, 3'b110})
      $display("FAIL div0_result: got %h_%h zero=%b div0=%b ill=%b need 0 1 1 0",
        sif.z_hi, sif.z_lo, sif.rsp_zero, sif.rsp_div0, sif.rsp_illegal);
    else pass_cnt++;
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    issue(4'b0100, 32'd3, 32'd3);
    wait_rsp(n);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      sif.req_valid = (i == 2);
      sif.req_op = 4'b0011;
      sif.req_a  = 32'd99;
      if ({sif.rsp_valid, sif.req_ready, sif.rsp_zero, sif.z_hi, sif.z_lo} !== {3'b101, 64'd0}) bad++;
      tick();
    end
    sif.req_valid = 1'b0;
    total_cnt++;
    if (bad !== 0 || n !== 1)
      $display("FAIL bp_hold: got %0d bad cycles latency=%0d need 0 and 1", bad, n);
    else pass_cnt++;
    total_cnt++;
    if ({sif.rsp_valid, sif.alu_op, sif.alu_a} !== {1'b1, 4'b0100, 32'd3})
      $display("FAIL bp_no_accept: got valid=%b op=%h a=%0d need 1 4 3", sif.rsp_valid, sif.alu_op, sif.alu_a);
    else pass_cnt++;
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
    total_cnt++;
    if ({sif.req_ready, sif.rsp_valid} !== 2'b10)
      $display("FAIL bp_release: got ready=%b valid=%b need 1 0", sif.req_ready, sif.rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4'b0011, 32'd1, 32'd2);
    wait_rsp(n);
    sif.rsp_ready = 1'b1;
    sif.req_valid = 1'b1;
    sif.req_op = 4'b0011;
    sif.req_a  = 32'd10;
    sif.req_b  = 32'd20;
    tick();
    sif.rsp_ready = 1'b0;
    total_cnt++;
    if ({sif.busy, sif.alu_a} !== {1'b0, 32'd1})
      $display("FAIL b2b_handshake_edge: got busy=%b a=%0d need 0 1", sif.busy, sif.alu_a);
    else pass_cnt++;
    tick();
    sif.req_valid = 1'b0;
    total_cnt++;
    if ({sif.busy, sif.alu_a} !== {1'b1, 32'd10})
      $display("FAIL b2b_accept: got busy=%b a=%0d need 1 10", sif.busy, sif.alu_a);
    else pass_cnt++;
    wait_rsp(n);
    total_cnt++;
    if ({n, sif.z_lo} !== {32'd1, 32'd30})
      $display("FAIL b2b_result: got lat=%0d z_lo=%0d need 1 30", n, sif.z_lo);
    else pass_cnt++;
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
  endtask

  task automatic test_clear_abort();
    int n;
    int seen;
    issue(4'b0110, 32'd100, 32'd7);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total_cnt++;
    if ({sif.req_ready, sif.rsp_valid, sif.busy, sif.z_hi, sif.z_lo} !== {3'b100, 64'd0})
      $display("FAIL clear_abort: got ready=%b valid=%b busy=%b z=%h_%h need 1 0 0 0",
        sif.req_ready, sif.rsp_valid, sif.busy, sif.z_hi, sif.z_lo);
    else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sif.rsp_valid) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL clear_no_rsp: got %0d valid cycles need 0", seen);
    else pass_cnt++;
    issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    wait_rsp(n);
    total_cnt++;
    if ({n, sif.z_hi, sif.z_lo} !== {32'd1, 32'd0, 32'h00F0_00F0})
      $display("FAIL clear_then_and: got lat=%0d z=%h_%h need 1 0_00f000f0", n, sif.z_hi, sif.z_lo);
    else pass_cnt++;
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    int n;
    issue(4'b1111, 32'd5, 32'd6);
    wait_rsp(n);
    total_cnt++;
    if (n !== 1) $display("FAIL illegal_latency: got %0d need 1", n);
    else pass_cnt++;
    total_cnt++;
    if ({sif.z_hi, sif.z_lo, sif.rsp_zero, sif.rsp_div0, sif.rsp_illegal} !== {64'd0, 3'b101})
      $display("FAIL illegal_result: got %h_%h zero=%b div0=%b ill=%b need 0 1 0 1",
        sif.z_hi, sif.z_lo, sif.rsp_zero, sif.rsp_div0, sif.rsp_illegal);
    else pass_cnt++;
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
    issue(4'b0011, 32'd2, 32'd2);
    wait_rsp(n);
    total_cnt++;
    if ({sif.rsp_illegal, sif.rsp_zero, sif.z_lo} !== {2'b00, 32'd4})
      $display("FAIL illegal_cleared: got ill=%b zero=%b z_lo=%0d need 0 0 4",
        sif.rsp_illegal, sif.rsp_zero, sif.z_lo);
    else pass_cnt++;
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    clear = 1'b1;
    sif.req_valid = 1'b0;
    sif.req_op = '0;
    sif.req_a = '0;
    sif.req_b = '0;
    sif.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_clear_abort();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
